stage_memory: RTL and testbench
===============================

STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL: valid_in  input  1  EX/MEM entry valid.
REQ-004 SHALL: memread, memwrite, memtoreg_in, regwrite_in  input  1 each  control from EX/MEM.
REQ-005 SHALL: size  input  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-006 SHALL: sign_ext  input  1  sign-extend (1) or zero-extend (0) byte/half loads.
REQ-007 SHALL: writereg_in  input  5  destination register.
REQ-008 SHALL: aluresult_in, writedata_in  input  32 each  effective address / ALU value; store data.
REQ-009 SHALL: stall  output  1  hold EX/MEM inputs stable and freeze upstream stages.
REQ-010 SHALL: dmem_req, dmem_we  output  1 each  data-memory request; write enable.
REQ-011 SHALL: dmem_addr  output  32  word-aligned address (bits [1:0] = 00).
REQ-012 SHALL: dmem_wdata  output  32; dmem_be  output  4  store data; byte enables.
REQ-013 SHALL: dmem_ack  input  1; dmem_rdata  input  32  completion strobe; read data valid with ack.
REQ-014 SHALL: valid_out, memtoreg, regwrite, misalign  output  1 each  MEM/WB register outputs.
REQ-015 SHALL: writereg  output  5; aluresult, readdata  output  32 each  MEM/WB register outputs feeding writeback.

Function
REQ-016 SHALL: FSM states IDLE and REQ; memop = valid_in & (memread | memwrite) & ~misaligned.
REQ-017 SHALL: misaligned = (half & addr[0]) | (word & addr[1:0]!=00); byte never misaligned.
REQ-018 SHALL: IDLE & memop -> REQ; latch word address, we, be, wdata, size, sign_ext, addr[1:0] into request registers; stall=1 that cycle.
REQ-019 SHALL: REQ drives dmem_req=1 from registers, constant until ack; ack -> IDLE, MEM/WB register loads on that edge, stall=0 that cycle.
REQ-020 SHALL: REQ & ~ack -> stay REQ, stall=1; minimum memory-op latency 2 cycles, no upper bound.
REQ-021 SHALL: IDLE & non-memory valid entry -> MEM/WB loads next edge, stall=0, no dmem_req.
REQ-022 SHALL: IDLE & misaligned -> no dmem_req; MEM/WB loads with misalign=1, regwrite=0, valid_out=1.
REQ-023 SHALL: IDLE & valid_in=0 -> MEM/WB loads valid_out=0, regwrite=0 (bubble).
REQ-024 SHALL: byte enables little-endian: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
REQ-025 SHALL: store data replicated: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-026 SHALL: load data: selected byte/half from dmem_rdata by latched addr[1:0], extended to 32 per sign_ext; word unmodified.
REQ-027 SHALL: stores load MEM/WB with regwrite=0 regardless of regwrite_in; readdata=0 for stores/non-loads.
REQ-028 SHALL: dmem_ack in IDLE ignored.
REQ-029 SHALL: aluresult, writereg, memtoreg pass through unchanged into MEM/WB.

Reset
REQ-030 SHALL: rst_n=0 -> state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, all MEM/WB outputs 0, stall=0 (async).
REQ-031 SHALL: reset during REQ abandons request; any later ack ignored per REQ-028.

Structure
REQ-032 SHALL: shared package mips_pkg holds mem_size_t (BYTE/HALF/WORD), memstate_t (IDLE/REQ), data width 32.
REQ-033 SHALL: one sub-module load_align (rdata, addr[1:0], size, sign_ext -> 32-bit result), combinational.

Verification
REQ-034 SHALL: lw addr 0x100, ack after 3 REQ cycles, rdata 0xDEADBEEF -> stall 4 cycles, readdata 0xDEADBEEF, regwrite=1.
REQ-035 SHALL: lb sign_ext=1 addr 0x103, rdata 0x80xxxxxx -> dmem_addr 0x100, readdata 0xFFFFFF80; lbu -> 0x00000080.
REQ-036 SHALL: sh addr 0x202 wd 0x1234ABCD -> dmem_be 1100, dmem_wdata 0xABCDABCD, dmem_we=1, regwrite=0.
REQ-037 SHALL: lw addr 0x101 -> no dmem_req, misalign=1, regwrite=0, stall=0.
REQ-038 SHALL: rst_n low during REQ, then ack -> dmem_req 0 immediately, ack ignored, outputs 0.
REQ-039 SHALL: back-to-back add then sw with ack on first REQ cycle -> add in MEM/WB next edge, sw completes 2 cycles later.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: access sizes, memory-stage FSM states and
// helpers for alignment, byte-lane enables and store-data replication.
package mips_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } memstate_t;

  // Size 2'b11 falls into the default arm and is handled as a word.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lo);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(logic [1:0] size, logic [1:0] lo);
    case (size)
      BYTE:    return 4'b0001 << lo;
      HALF:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DataWidth-1:0] store_data(logic [1:0] size,
                                                      logic [DataWidth-1:0] wd);
    case (size)
      BYTE:    return {4{wd[7:0]}};
      HALF:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a read word and extends it to 32 bits.
module load_align
  import mips_pkg::*;
(
  input  logic [DataWidth-1:0] rdata,
  input  logic [1:0]           addr,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  output logic [DataWidth-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      BYTE:    result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      HALF:    result = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls
// upstream until the ack, and registers the MEM/WB outputs.
module stage_memory
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 memread,
  input  logic                 memwrite,
  input  logic                 memtoreg_in,
  input  logic                 regwrite_in,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [4:0]           writereg_in,
  input  logic [DataWidth-1:0] aluresult_in,
  input  logic [DataWidth-1:0] writedata_in,
  output logic                 stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DataWidth-1:0] dmem_addr,
  output logic [DataWidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ack,
  input  logic [DataWidth-1:0] dmem_rdata,
  output logic                 valid_out,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 misalign,
  output logic [4:0]           writereg,
  output logic [DataWidth-1:0] aluresult,
  output logic [DataWidth-1:0] readdata
);

  memstate_t            state;
  logic [1:0]           size_q;
  logic [1:0]           lo_q;
  logic                 sign_ext_q;
  logic                 is_mem;
  logic                 misaligned;
  logic                 memop;
  logic [DataWidth-1:0] load_data;

  assign is_mem     = valid_in & (memread | memwrite);
  assign misaligned = is_misaligned(size, aluresult_in[1:0]);
  assign memop      = is_mem & ~misaligned;

  // Gated by rst_n so stall is low throughout an asynchronous reset.
  assign stall = rst_n & ((state == IDLE) ? memop : ~dmem_ack);

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .addr     (lo_q),
    .size     (size_q),
    .sign_ext (sign_ext_q),
    .result   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      sign_ext_q <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      valid_out  <= 1'b0;
      memtoreg   <= 1'b0;
      regwrite   <= 1'b0;
      misalign   <= 1'b0;
      writereg   <= 5'd0;
      aluresult  <= '0;
      readdata   <= '0;
    end else begin
      aluresult <= aluresult_in;
      writereg  <= writereg_in;
      memtoreg  <= memtoreg_in;
      // Stall edges load a bubble so writeback never commits an entry twice.
      valid_out <= 1'b0;
      regwrite  <= 1'b0;
      misalign  <= 1'b0;
      readdata  <= '0;
      case (state)
        IDLE: begin
          if (memop) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite;
            dmem_addr  <= {aluresult_in[DataWidth-1:2], 2'b00};
            dmem_wdata <= store_data(size, writedata_in);
            dmem_be    <= byte_enable(size, aluresult_in[1:0]);
            size_q     <= size;
            lo_q       <= aluresult_in[1:0];
            sign_ext_q <= sign_ext;
          end else begin
            valid_out <= valid_in;
            regwrite  <= valid_in & regwrite_in & ~is_mem;
            misalign  <= is_mem & misaligned;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            valid_out <= 1'b1;
            regwrite  <= regwrite_in & ~dmem_we;
            readdata  <= dmem_we ? '0 : load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory with a transaction-level reference model
// checked every cycle, plus literal expectations for key scenarios.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, memread, memwrite, memtoreg_in, regwrite_in, sign_ext;
  logic [1:0]  size;
  logic [4:0]  writereg_in;
  logic [31:0] aluresult_in, writedata_in;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_out, memtoreg, regwrite, misalign;
  logic [4:0]  writereg;
  logic [31:0] aluresult, readdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stage_memory dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .memread      (memread),
    .memwrite     (memwrite),
    .memtoreg_in  (memtoreg_in),
    .regwrite_in  (regwrite_in),
    .size         (size),
    .sign_ext     (sign_ext),
    .writereg_in  (writereg_in),
    .aluresult_in (aluresult_in),
    .writedata_in (writedata_in),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .valid_out    (valid_out),
    .memtoreg     (memtoreg),
    .regwrite     (regwrite),
    .misalign     (misalign),
    .writereg     (writereg),
    .aluresult    (aluresult),
    .readdata     (readdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written as plain arithmetic on the address and data.
  function automatic logic f_misal(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] f_be(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wd(logic [1:0] sz, logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] f_load(logic [31:0] r, logic [1:0] lo, logic [1:0] sz,
                                         logic sx);
    logic [31:0] v;
    if (sz >= 2'd2) return r;
    if (sz == 2'd0) begin
      v = (r >> (8 * int'(lo))) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (r >> (16 * (int'(lo) / 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Model: one outstanding transaction plus the expected MEM/WB contents.
  logic        m_busy, m_we, m_sx;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [1:0]  m_lo, m_size;
  logic        e_valid, e_m2r, e_rw, e_mis;
  logic [4:0]  e_wreg;
  logic [31:0] e_alu, e_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_we = 0; m_sx = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      m_lo = 0; m_size = 0;
      e_valid = 0; e_m2r = 0; e_rw = 0; e_mis = 0; e_wreg = 0; e_alu = 0; e_rd = 0;
    end else begin
      e_alu = aluresult_in; e_wreg = writereg_in; e_m2r = memtoreg_in;
      e_valid = 0; e_rw = 0; e_mis = 0; e_rd = 0;
      if (m_busy) begin
        if (dmem_ack) begin
          e_valid = 1;
          e_rw    = regwrite_in && !m_we;
          e_rd    = m_we ? 32'd0 : f_load(dmem_rdata, m_lo, m_size, m_sx);
          m_busy  = 0;
        end
      end else if (valid_in && (memread || memwrite)) begin
        if (f_misal(size, aluresult_in)) begin
          e_valid = 1;
          e_mis   = 1;
        end else begin
          m_busy  = 1;
          m_we    = memwrite;
          m_addr  = aluresult_in - (aluresult_in % 4);
          m_be    = f_be(size, aluresult_in);
          m_wdata = f_wd(size, writedata_in);
          m_lo    = aluresult_in[1:0];
          m_size  = size;
          m_sx    = sign_ext;
        end
      end else begin
        e_valid = valid_in;
        e_rw    = valid_in && regwrite_in;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    if (!rst_n) exp_stall = 0;
    else if (!m_busy)
      exp_stall = valid_in && (memread || memwrite) && !f_misal(size, aluresult_in);
    else exp_stall = !dmem_ack;
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("dmem_req", 32'(dmem_req), 32'(m_busy));
    if (m_busy) begin
      chk("dmem_addr", dmem_addr, m_addr);
      chk("dmem_we", 32'(dmem_we), 32'(m_we));
      chk("dmem_be", 32'(dmem_be), 32'(m_be));
      chk("dmem_wdata", dmem_wdata, m_wdata);
    end
    chk("valid_out", 32'(valid_out), 32'(e_valid));
    chk("memtoreg", 32'(memtoreg), 32'(e_m2r));
    chk("regwrite", 32'(regwrite), 32'(e_rw));
    chk("misalign", 32'(misalign), 32'(e_mis));
    chk("writereg", 32'(writereg), 32'(e_wreg));
    chk("aluresult", aluresult, e_alu);
    chk("readdata", readdata, e_rd);
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [1:0] sz, input logic sx,
                       input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] wd);
    valid_in = v; memread = rd; memwrite = wr; memtoreg_in = m2r; regwrite_in = rw;
    size = sz; sign_ext = sx; writereg_in = wreg; aluresult_in = alu; writedata_in = wd;
  endtask

  // One clock: present ack/rdata, sample stall mid-cycle, step past the edge.
  task automatic cyc(input logic ack, input logic [31:0] rd, output logic st);
    dmem_ack = ack; dmem_rdata = rd;
    @(negedge clk);
    st = stall;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic st;
    int   nst;
    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive(0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 32'd0, 32'd0);
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lw 0x100, three waiting REQ cycles, then ack
    drive(1, 1, 0, 1, 1, 2'd2, 0, 5'd8, 32'h100, 32'd0);
    nst = 0;
    cyc(0, 32'd0, st); nst += int'(st);
    repeat (3) begin cyc(0, 32'd0, st); nst += int'(st); end
    cyc(1, 32'hDEAD_BEEF, st); nst += int'(st);
    chk("lw_stall_cycles", 32'(nst), 32'd4);
    chk("lw_readdata", readdata, 32'hDEAD_BEEF);
    chk("lw_regwrite", 32'(regwrite), 32'd1);

    // lb / lbu at 0x103
    drive(1, 1, 0, 1, 1, 2'd0, 1, 5'd9, 32'h103, 32'd0);
    cyc(0, 32'd0, st);
    chk("lb_dmem_addr", dmem_addr, 32'h100);
    cyc(1, 32'h8012_3456, st);
    chk("lb_readdata", readdata, 32'hFFFF_FF80);
    drive(1, 1, 0, 1, 1, 2'd0, 0, 5'd9, 32'h103, 32'd0);
    cyc(0, 32'd0, st);
    cyc(1, 32'h8012_3456, st);
    chk("lbu_readdata", readdata, 32'h0000_0080);

    // sh 0x202
    drive(1, 0, 1, 0, 1, 2'd1, 0, 5'd10, 32'h202, 32'h1234_ABCD);
    cyc(0, 32'd0, st);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dmem_we), 32'd1);
    cyc(1, 32'd0, st);
    chk("sh_regwrite", 32'(regwrite), 32'd0);
    chk("sh_valid_out", 32'(valid_out), 32'd1);

    // sb 0x301 and lh (sign-extended) 0x202, model-checked
    drive(1, 0, 1, 0, 0, 2'd0, 0, 5'd0, 32'h301, 32'h0000_0055);
    cyc(0, 32'd0, st);
    cyc(1, 32'd0, st);
    drive(1, 1, 0, 1, 1, 2'd1, 1, 5'd11, 32'h202, 32'd0);
    cyc(0, 32'd0, st);
    cyc(0, 32'd0, st);
    cyc(1, 32'h8001_1234, st);
    chk("lh_readdata", readdata, 32'hFFFF_8001);

    // misaligned lw 0x101
    drive(1, 1, 0, 1, 1, 2'd2, 0, 5'd12, 32'h101, 32'd0);
    cyc(0, 32'd0, st);
    chk("mis_stall", 32'(st), 32'd0);
    chk("mis_misalign", 32'(misalign), 32'd1);
    chk("mis_regwrite", 32'(regwrite), 32'd0);
    chk("mis_valid_out", 32'(valid_out), 32'd1);
    chk("mis_dmem_req", 32'(dmem_req), 32'd0);

    // bubble with a stray ack while idle
    drive(0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 32'd0, 32'd0);
    cyc(1, 32'h1111_1111, st);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("bubble_valid_out", 32'(valid_out), 32'd0);

    // add then sw, ack on the first REQ cycle
    drive(1, 0, 0, 0, 1, 2'd2, 0, 5'd13, 32'h77, 32'd0);
    cyc(0, 32'd0, st);
    chk("add_stall", 32'(st), 32'd0);
    chk("add_aluresult", aluresult, 32'h77);
    chk("add_valid_out", 32'(valid_out), 32'd1);
    drive(1, 0, 1, 0, 0, 2'd2, 0, 5'd0, 32'h400, 32'hCAFE_F00D);
    cyc(0, 32'd0, st);
    chk("sw_issue_stall", 32'(st), 32'd1);
    cyc(1, 32'd0, st);
    chk("sw_ack_stall", 32'(st), 32'd0);
    chk("sw_aluresult", aluresult, 32'h400);
    chk("sw_valid_out", 32'(valid_out), 32'd1);

    // reset in the middle of a request, then a late ack
    drive(1, 1, 0, 1, 1, 2'd2, 0, 5'd14, 32'h500, 32'd0);
    cyc(0, 32'd0, st);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_req_stall", 32'(stall), 32'd0);
    chk("rst_req_valid_out", 32'(valid_out), 32'd0);
    chk("rst_req_addr", dmem_addr, 32'd0);
    drive(0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 32'd0, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 32'h2222_2222, st);
    cyc(1, 32'h2222_2222, st);
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_valid", 32'(valid_out), 32'd0);
    chk("late_ack_readdata", readdata, 32'd0);

    repeat (2) cyc(0, 32'd0, st);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
